// File: rtl/mips_mc_controller_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// The controller takes the master side; the datapath (or a bench standing in for it) takes the slave side.
interface mips_mc_controller_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemToReg;
  logic       RegDst;
  logic       IorD;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       IRWrite;
  logic       MemWrite;
  logic       PCWrite;
  logic       Branch;
  logic       RegWrite;
  logic [2:0] ALUControl;
  logic [3:0] State;

  modport master (
    input  Opcode, Funct, Zero,
    output MemToReg, RegDst, IorD, PCSrc, PCEn, ALUSrcA, ALUSrcB,
           IRWrite, MemWrite, PCWrite, Branch, RegWrite, ALUControl, State
  );

  modport slave (
    output Opcode, Funct, Zero,
    input  MemToReg, RegDst, IorD, PCSrc, PCEn, ALUSrcA, ALUSrcB,
           IRWrite, MemWrite, PCWrite, Branch, RegWrite, ALUControl, State
  );
endinterface

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore main-decoder FSM, combinational ALU decoder and PC enable.
// While reset_n is low every strobe is held inactive so a reset never leaves a partial write behind.
module mips_mc_controller (
  input  logic                    clk,
  input  logic                    reset_n,
  mips_mc_controller_if.master    bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
  } state_t;

  state_t     state, next_state;
  logic       mem_to_reg, reg_dst, iord, alu_src_a;
  logic       ir_write, mem_write, pc_write, branch, reg_write;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [2:0] alu_control;

  // NOTE: reset is sampled on the clock edge only, and state uses <= so every
  // flop in the design updates from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= FETCH;
    else          state <= next_state;
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    next_state = FETCH;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    iord       = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    alu_op     = 2'b00;
    case (state)
      FETCH: begin
        alu_src_b  = 2'b01;
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (bus.Opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXEC;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = (bus.Opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord       = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        next_state = ALUWB;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = ADDIWB;
      end
      ADDIWB: reg_write = 1'b1;
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: next_state = FETCH;
    endcase
  end

  // ALU op is zeroed during reset so the decoder falls back to add.
  always_comb begin
    alu_control = 3'b010;
    case (reset_n ? alu_op : 2'b00)
      2'b01: alu_control = 3'b110;
      2'b10: begin
        case (bus.Funct)
          6'b100010: alu_control = 3'b110;
          6'b100100: alu_control = 3'b000;
          6'b100101: alu_control = 3'b001;
          6'b101010: alu_control = 3'b111;
          default:   alu_control = 3'b010;
        endcase
      end
      default: alu_control = 3'b010;
    endcase
  end

  always_comb begin
    bus.MemToReg   = reset_n & mem_to_reg;
    bus.RegDst     = reset_n & reg_dst;
    bus.IorD       = reset_n & iord;
    bus.PCSrc      = reset_n ? pc_src : 2'b00;
    bus.ALUSrcA    = reset_n & alu_src_a;
    bus.ALUSrcB    = reset_n ? alu_src_b : 2'b00;
    bus.IRWrite    = reset_n & ir_write;
    bus.MemWrite   = reset_n & mem_write;
    bus.PCWrite    = reset_n & pc_write;
    bus.Branch     = reset_n & branch;
    bus.RegWrite   = reset_n & reg_write;
    bus.PCEn       = reset_n & (pc_write | (branch & bus.Zero));
    bus.ALUControl = alu_control;
    bus.State      = reset_n ? state : FETCH;
  end

endmodule
